// File: rtl/seq_mult_if.sv
// seq_mult_if: ld / mult_ok multiply handshake between an initiator and the
// seq_mult responder.
//   ld        initiator -> responder  start request (rising edge starts)
//   mult1     initiator -> responder  multiplicand, unsigned, WIDTH bits
//   mult2     initiator -> responder  multiplier, unsigned, WIDTH bits
//   mult_res  responder -> initiator  last completed product, 2*WIDTH bits
//   mult_ok   responder -> initiator  one-cycle result-valid strobe
//   busy      responder -> initiator  multiply in progress
//   dbg       responder -> initiator  current state encoding
interface seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                   ld;
    logic [WIDTH-1:0]       mult1;
    logic [WIDTH-1:0]       mult2;
    logic [2*WIDTH-1:0]     mult_res;
    logic                   mult_ok;
    logic                   busy;
    logic [1:0]             dbg;

    modport master (
        output ld, mult1, mult2,
        input  mult_res, mult_ok, busy, dbg
    );

    modport slave (
        input  ld, mult1, mult2,
        output mult_res, mult_ok, busy, dbg
    );
endinterface

// File: rtl/seq_mult.sv
// seq_mult: sequential shift-add unsigned multiplier, responder side of the
// ld / mult_ok handshake. One multiply in flight; fixed latency of WIDTH
// edges from the start edge to the mult_ok cycle.
//   clk    system clock, rising edge
//   reset  synchronous reset, active-low
//   bus    seq_mult_if slave modport (ld, mult1, mult2 in;
//          mult_res, mult_ok, busy, dbg out)
//
// state  | meaning
// IDLE   | waiting for a rising edge on ld
// RUN    | one shift-add step per edge, WIDTH steps
// DONE   | mult_ok pulse cycle, then back to IDLE
// (3)    | unused, recovers to IDLE
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    seq_mult_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DONE   = 2'd2,
        S_UNUSED = 2'd3
    } state_t;

    state_t               state;
    logic                 ld_q;
    logic [2*WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]     b_sh;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   res_q;
    logic                 ok_q;
    logic                 busy_q;

    logic                 start;
    logic [2*WIDTH-1:0]   acc_next;

    always_comb begin
        start    = bus.ld & ~ld_q;
        acc_next = b_sh[0] ? (acc + a_sh) : acc;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            ld_q   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            cnt    <= '0;
            res_q  <= '0;
            ok_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            // ld_q tracks ld in every state so a level held through a
            // multiply cannot look like a fresh edge once back in IDLE.
            ld_q <= bus.ld;
            case (state)
                S_IDLE: begin
                    ok_q <= 1'b0;
                    if (start) begin
                        a_sh   <= {{WIDTH{1'b0}}, bus.mult1};
                        b_sh   <= bus.mult2;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc  <= acc_next;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        res_q <= acc_next;
                        ok_q  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ok_q   <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    ok_q   <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mult_res = res_q;
    assign bus.mult_ok  = ok_q;
    assign bus.busy     = busy_q;
    assign bus.dbg      = state;
endmodule

// File: tb/tb_seq_mult.sv
module tb_seq_mult;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    logic prev_ok = 1'b0;
    logic [15:0] exp_q[$];

    seq_mult_if #(.WIDTH(8)) bus ();

    seq_mult #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every mult_ok cycle consumes one expected product.
    always @(negedge clk) begin
        if (bus.mult_ok === 1'b1) begin
            pulses++;
            total++;
            if (prev_ok) begin
                bad++;
                $display("FAIL ok_width: got 2+ cycles expected 1");
            end
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ok: got result %0h expected no pulse", bus.mult_res);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.mult_res !== e) begin
                    bad++;
                    $display("FAIL mult_res: got %0h expected %0h", bus.mult_res, e);
                end
            end
        end
        prev_ok = (bus.mult_ok === 1'b1);
    end

    // Waits for mult_ok, checks latency from start edge t0, then drops ld
    // on the mult_ok cycle like a real initiator.
    task automatic wait_ok(input int t0, input string name, input bit drop_ld);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) check({name, "_busy_run"}, bus.busy, 1);
            if (bus.mult_ok === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no mult_ok expected pulse", name);
        end else begin
            check({name, "_latency"}, cyc - t0, 8);
            check({name, "_busy_ok"}, bus.busy, 1);
            if (drop_ld) bus.ld = 1'b0;
            @(negedge clk);
            check({name, "_ok_low"}, bus.mult_ok, 0);
            check({name, "_busy_idle"}, bus.busy, 0);
        end
    endtask

    task automatic do_mult(input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] e, input string name);
        int t0;
        int p0;
        p0 = pulses;
        bus.mult1 = a;
        bus.mult2 = b;
        bus.ld    = 1'b1;
        t0 = cyc + 1;
        exp_q.push_back(e);
        wait_ok(t0, name, 1);
        check({name, "_pulses"}, pulses - p0, 1);
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int p0;
        bus.ld = 1'b0;
        bus.mult1 = '0;
        bus.mult2 = '0;
        repeat (3) @(negedge clk);
        check("rst_res", bus.mult_res, 0);
        check("rst_ok", bus.mult_ok, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_dbg", bus.dbg, 0);
        reset = 1'b1;
        @(negedge clk);

        do_mult(8'hFF, 8'hFF, 16'hFE01, "full");
        do_mult(8'h00, 8'hA5, 16'h0000, "zero");
        do_mult(8'h01, 8'hA5, 16'h00A5, "ident");
        do_mult(8'h80, 8'h02, 16'h0100, "pow2");

        do_mult(8'h80, 8'hFF, 16'h7F80, "chain0");
        do_mult(8'h80, 8'h40, 16'h2000, "chain1");
        do_mult(8'h80, 8'h00, 16'h0000, "chain2");
        do_mult(8'h80, 8'hC8, 16'h6400, "chain3");

        // ld held high for 30 cycles: exactly one multiply.
        p0 = pulses;
        bus.mult1 = 8'h03;
        bus.mult2 = 8'h05;
        bus.ld = 1'b1;
        exp_q.push_back(16'h000F);
        repeat (30) @(negedge clk);
        check("hold_pulses", pulses - p0, 1);
        check("hold_busy", bus.busy, 0);
        check("hold_dbg", bus.dbg, 0);
        bus.ld = 1'b0;
        repeat (2) @(negedge clk);

        // Operand change and ld toggle during RUN are ignored.
        p0 = pulses;
        bus.mult1 = 8'h10;
        bus.mult2 = 8'h10;
        bus.ld = 1'b1;
        t0 = cyc + 1;
        exp_q.push_back(16'h0100);
        repeat (3) @(negedge clk);
        check("midrun_dbg", bus.dbg, 1);
        bus.mult1 = 8'h33;
        bus.mult2 = 8'h44;
        bus.ld = 1'b0;
        @(negedge clk);
        bus.ld = 1'b1;
        while (bus.mult_ok !== 1'b1 && cyc - t0 < 20) @(negedge clk);
        check("midrun_latency", cyc - t0, 8);
        repeat (15) @(negedge clk);
        check("midrun_pulses", pulses - p0, 1);
        check("midrun_busy", bus.busy, 0);
        check("midrun_dbg_idle", bus.dbg, 0);
        check("midrun_res_held", bus.mult_res, 16'h0100);
        bus.ld = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during RUN aborts; ld held across release restarts at once.
        p0 = pulses;
        bus.mult1 = 8'hFF;
        bus.mult2 = 8'hFF;
        bus.ld = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ok", bus.mult_ok, 0);
        check("abort_res", bus.mult_res, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_pulses", pulses - p0, 0);
        reset = 1'b1;
        t0 = cyc + 1;
        exp_q.push_back(16'hFE01);
        wait_ok(t0, "restart", 1);
        check("restart_pulses", pulses - p0, 1);
        repeat (3) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Sequential shift-add unsigned multiplier. It is the responder side of the `ld` / `mult_ok` multiply handshake used by the colour-generation datapath.
- An initiator presents `mult1`/`mult2` and raises `ld`. The block computes the product serially, presents it on `mult_res` and pulses `mult_ok` for exactly one cycle.
- Shared by all initiator states, with one multiply in flight at a time. This saves area versus a combinational 8x8 array.

Parameters:
- WIDTH, 8, operand width in bits; `mult_res` is 2*WIDTH bits.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous reset, active-low
- ld  in  1  start request from initiator; a rising edge (as sampled on clk) starts a multiply
- mult1  in  WIDTH  multiplicand, unsigned
- mult2  in  WIDTH  multiplier, unsigned
- mult_res  out  2*WIDTH  product of the last completed multiply; held until the next completion
- mult_ok  out  1  result-valid strobe, high for exactly one cycle per completed multiply
- busy  out  1  high while a multiply is in progress (RUN or DONE)
- dbg  out  2  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-low. reset==0 at an edge forces:
  - state=IDLE
  - mult_res=0, mult_ok=0, busy=0
  - ld_q=0, accumulator=0, shift registers=0, counter=0
- Reset mid-operation aborts the multiply silently: no `mult_ok`, and `mult_res` is cleared to 0.
- Start detection: internal register ld_q <= ld every edge.
  - start = ld & ~ld_q, sampled in IDLE only.
  - A level-high `ld` never retriggers.
  - If `ld` is already high at reset release, the first edge after release counts as a start, because ld_q resets to 0.
- State IDLE (dbg=0):
  - On start: a_sh <= zero-extend(mult1) to 2*WIDTH, b_sh <= mult2, acc <= 0, cnt <= 0, state <= RUN.
  - Operands are sampled only at this edge; later changes on `mult1`/`mult2` have no effect.
- State RUN (dbg=1): every edge does:
  - if b_sh[0]: acc <= acc + a_sh (2*WIDTH-bit add; cannot overflow)
  - a_sh <= a_sh << 1, b_sh <= b_sh >> 1, cnt <= cnt + 1
- Last RUN step (cnt==WIDTH-1), on that edge:
  - mult_res <= final acc value, including this step's add
  - mult_ok <= 1, state <= DONE
- State DONE (dbg=2): next edge sets mult_ok <= 0 and state <= IDLE. A start detected in the DONE cycle is not honoured.
- Latency: if the start edge is t0, `mult_res` is valid and mult_ok=1 in the cycle after edge t0+WIDTH, and mult_ok=0 after edge t0+WIDTH+1. Constant latency; no early exit on zero operands.
- Why `mult_ok` is a single-cycle pulse: the initiator drops `ld` in the same edge it sees mult_ok=1 and moves on. A multi-cycle `mult_ok` would make the initiator capture a stale result.
- Re-arming: `ld` is normally still high during DONE. ld_q is then high, so no restart occurs until `ld` has gone low and risen again.
- busy = (state != IDLE).
- `ld` behaviour while busy:
  - Falling edge during RUN: ignored; the multiply completes and `mult_ok` pulses.
  - Rising edge during RUN/DONE: lost, not queued. ld_q still tracks `ld`, so a level held into IDLE does not start.
- Encoding 3 is unused. If entered, it transitions to IDLE with mult_ok=0.
- `mult_res` changes only at completion or reset.

Test Plan:
- Full-scale product: reset, then mult1=0xFF, mult2=0xFF, raise `ld` → mult_res=0xFE01 with mult_ok=1 for exactly one cycle, 8 edges after the start edge; busy high from start until after the pulse.
- Zero and identity: 0x00*0xA5 → 0x0000; 0x01*0xA5 → 0x00A5; 0x80*0x02 → 0x0100; each with the same 8-edge latency.
- Initiator-style chain of four multiplies (0x80 with 0xFF, 0x40, 0x00, 0xC8), where `ld` is dropped on the `mult_ok` cycle and re-raised only once `mult_ok` is 0 → results 0x7F80, 0x2000, 0x0000, 0x6400, each captured once with no stale capture.
- `ld` held high for 30 cycles with 0x03*0x05 → exactly one `mult_ok` pulse with mult_res=0x000F; no retrigger.
- mult1/mult2 changed and `ld` toggled at cycle 3 of RUN (operands 0x10*0x10) → mult_res=0x0100, exactly one `mult_ok` pulse, the new request is ignored, and the block returns to IDLE.
- Reset asserted at cycle 4 of RUN (0xFF*0xFF) → no `mult_ok` pulse, mult_res=0 and busy=0 on the next cycle; `ld` held high across release → a new multiply starts on the first edge after release.
